// File: rtl/mem_wb_reg_pkg.sv
// Shared definitions for the MEM/WB stage: load-type and write-back-select
// encodings, the default reset PC, and sub-word extension helpers.
package mem_wb_reg_pkg;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  // Extend a byte to a word; sgn selects sign (1) or zero (0) extension.
  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  // Extend a halfword to a word; sgn selects sign (1) or zero (0) extension.
  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_wb_reg_load_ext.sv
// Load formatter: picks the addressed byte/halfword out of a little-endian
// memory word and sign- or zero-extends it. Purely combinational.
module load_ext
  import mem_wb_reg_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  load_type,
  output logic [31:0] value
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Byte-lane and halfword-lane selection from the low address bits.
  always_comb begin
    byte_s = 8'h00;
    case (off)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      2'd3:    byte_s = word[31:24];
      default: byte_s = 8'h00;
    endcase
    // off[0] is not looked at for halfwords: alignment is enforced upstream.
    if (off[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
  end

  // Extension according to load type; unknown encodings behave as LW.
  always_comb begin
    value = word;
    case (load_type)
      LD_LB:   value = ext8(byte_s, 1'b1);
      LD_LBU:  value = ext8(byte_s, 1'b0);
      LD_LH:   value = ext16(half_s, 1'b1);
      LD_LHU:  value = ext16(half_s, 1'b0);
      default: value = word;
    endcase
  end

endmodule

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register and write-back formatter.
// Optional feature: define RETIRE_CNT_EN to build the 32-bit retired
// instruction counter; otherwise retire_cnt is tied to zero.
module mem_wb_reg
  import mem_wb_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_M,
  input  logic [31:0] PC_M,
  input  logic        RegWrite_M,
  input  logic [4:0]  WAddr_M,
  input  logic [31:0] ALUOut_M,
  input  logic [31:0] MemData_M,
  input  logic [2:0]  LoadType_M,
  input  logic [1:0]  WBSel_M,
  input  logic        stall_W,
  input  logic        flush_W,
  output logic        valid_W,
  output logic [31:0] PC_W,
  output logic [4:0]  WAddr_W,
  output logic [31:0] WriteData_W,
  output logic        RegWrite_W,
  output logic [31:0] retire_cnt
);

  logic        valid_r;
  logic [31:0] pc_r;
  logic        regwrite_r;
  logic [4:0]  waddr_r;
  logic [31:0] aluout_r;
  logic [31:0] memdata_r;
  logic [2:0]  loadtype_r;
  logic [1:0]  wbsel_r;
  logic [31:0] load_val_s;
  logic [31:0] wdata_s;

  // W-stage register: flush beats stall, stall holds, otherwise capture M.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r    <= 1'b0;
      pc_r       <= RESET_PC;
      regwrite_r <= 1'b0;
      waddr_r    <= 5'd0;
      aluout_r   <= 32'd0;
      memdata_r  <= 32'd0;
      loadtype_r <= 3'd0;
      wbsel_r    <= 2'd0;
    end else if (flush_W) begin
      valid_r    <= 1'b0;
      pc_r       <= RESET_PC;
      regwrite_r <= 1'b0;
      waddr_r    <= 5'd0;
      aluout_r   <= 32'd0;
      memdata_r  <= 32'd0;
      loadtype_r <= 3'd0;
      wbsel_r    <= 2'd0;
    end else if (!stall_W) begin
      valid_r    <= valid_M;
      pc_r       <= PC_M;
      regwrite_r <= RegWrite_M;
      waddr_r    <= WAddr_M;
      aluout_r   <= ALUOut_M;
      memdata_r  <= MemData_M;
      loadtype_r <= LoadType_M;
      wbsel_r    <= WBSel_M;
    end else begin
      valid_r    <= valid_r;
      pc_r       <= pc_r;
      regwrite_r <= regwrite_r;
      waddr_r    <= waddr_r;
      aluout_r   <= aluout_r;
      memdata_r  <= memdata_r;
      loadtype_r <= loadtype_r;
      wbsel_r    <= wbsel_r;
    end
  end

  load_ext u_load_ext (
    .word      (memdata_r),
    .off       (aluout_r[1:0]),
    .load_type (loadtype_r),
    .value     (load_val_s)
  );

  // Write-back select; an empty slot always presents zero data.
  always_comb begin
    wdata_s = 32'd0;
    if (valid_r) begin
      case (wbsel_r)
        WB_MEM:  wdata_s = load_val_s;
        WB_LINK: wdata_s = pc_r + 32'd8;
        default: wdata_s = aluout_r;
      endcase
    end else begin
      wdata_s = 32'd0;
    end
  end

  assign valid_W     = valid_r;
  assign PC_W        = pc_r;
  assign WAddr_W     = waddr_r;
  assign WriteData_W = wdata_s;
  // $0 is hard-wired and empty slots must never write.
  assign RegWrite_W  = regwrite_r & valid_r & (waddr_r != 5'd0);

`ifdef RETIRE_CNT_EN
  logic [31:0] retire_cnt_r;

  // Count each valid W slot that leaves the stage (advance or flush).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_cnt_r <= 32'd0;
    end else if ((flush_W || !stall_W) && valid_r) begin
      retire_cnt_r <= retire_cnt_r + 32'd1;
    end else begin
      retire_cnt_r <= retire_cnt_r;
    end
  end

  assign retire_cnt = retire_cnt_r;
`else
  assign retire_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_wb_reg.sv
// Self-checking bench for mem_wb_reg: directed cases with literal
// expectations plus randomized traffic against a behavioural model.
module tb_mem_wb_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_M = 1'b0;
  logic [31:0] PC_M = 32'd0;
  logic        RegWrite_M = 1'b0;
  logic [4:0]  WAddr_M = 5'd0;
  logic [31:0] ALUOut_M = 32'd0;
  logic [31:0] MemData_M = 32'd0;
  logic [2:0]  LoadType_M = 3'd0;
  logic [1:0]  WBSel_M = 2'd0;
  logic        stall_W = 1'b0;
  logic        flush_W = 1'b0;
  logic        valid_W;
  logic [31:0] PC_W;
  logic [4:0]  WAddr_W;
  logic [31:0] WriteData_W;
  logic        RegWrite_W;
  logic [31:0] retire_cnt;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // model of the W-stage outputs
  logic        m_valid = 1'b0;
  logic [31:0] m_pc    = 32'h0000_3000;
  logic [4:0]  m_waddr = 5'd0;
  logic [31:0] m_wd    = 32'd0;
  logic        m_we    = 1'b0;
  logic [31:0] m_cnt   = 32'd0;

  mem_wb_reg dut (
    .clk(clk), .reset(reset), .valid_M(valid_M), .PC_M(PC_M),
    .RegWrite_M(RegWrite_M), .WAddr_M(WAddr_M), .ALUOut_M(ALUOut_M),
    .MemData_M(MemData_M), .LoadType_M(LoadType_M), .WBSel_M(WBSel_M),
    .stall_W(stall_W), .flush_W(flush_W), .valid_W(valid_W), .PC_W(PC_W),
    .WAddr_W(WAddr_W), .WriteData_W(WriteData_W), .RegWrite_W(RegWrite_W),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Write-back value straight from the ISA rules.
  function automatic logic [31:0] wb_value(input logic [31:0] pc, input logic [31:0] alu,
                                           input logic [31:0] mem, input logic [2:0] lt,
                                           input logic [1:0] ws);
    int unsigned off, b, h;
    off = alu % 4;
    b = (mem >> (8 * off)) & 32'hFF;
    h = (off >= 2) ? (mem >> 16) : (mem & 32'hFFFF);
    if (ws == 2'd2) return pc + 32'd8;
    if (ws != 2'd1) return alu;
    case (lt)
      3'd1: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd2: return b;
      3'd3: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd4: return h;
      default: return mem;
    endcase
  endfunction

  // Reference model update.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid = 1'b0; m_pc = 32'h0000_3000; m_waddr = 5'd0; m_wd = 32'd0; m_we = 1'b0; m_cnt = 32'd0;
    end else begin
`ifdef RETIRE_CNT_EN
      if ((flush_W || !stall_W) && m_valid) m_cnt = m_cnt + 32'd1;
`endif
      if (flush_W) begin
        m_valid = 1'b0; m_pc = 32'h0000_3000; m_waddr = 5'd0; m_wd = 32'd0; m_we = 1'b0;
      end else if (!stall_W) begin
        m_valid = valid_M;
        m_pc    = PC_M;
        m_waddr = WAddr_M;
        m_wd    = valid_M ? wb_value(PC_M, ALUOut_M, MemData_M, LoadType_M, WBSel_M) : 32'd0;
        m_we    = RegWrite_M && valid_M && (WAddr_M != 5'd0);
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid_W", {31'd0, valid_W}, {31'd0, m_valid});
      check("PC_W", PC_W, m_pc);
      check("WAddr_W", {27'd0, WAddr_W}, {27'd0, m_waddr});
      check("WriteData_W", WriteData_W, m_wd);
      check("RegWrite_W", {31'd0, RegWrite_W}, {31'd0, m_we});
      check("retire_cnt", retire_cnt, m_cnt);
    end
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic rw, input logic [4:0] wa,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [2:0] lt,
                       input logic [1:0] ws, input logic st, input logic fl);
    valid_M = v; PC_M = pc; RegWrite_M = rw; WAddr_M = wa; ALUOut_M = alu;
    MemData_M = mem; LoadType_M = lt; WBSel_M = ws; stall_W = st; flush_W = fl;
  endtask

  // Drive at a negedge, let one posedge capture, return at the next negedge.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic rw, input logic [4:0] wa,
                     input logic [31:0] alu, input logic [31:0] mem, input logic [2:0] lt,
                     input logic [1:0] ws, input logic st, input logic fl);
    drive(v, pc, rw, wa, alu, mem, lt, ws, st, fl);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] held_wd;
    logic [31:0] exp_cnt;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_PC", PC_W, 32'h0000_3000);
    check("rst_valid", {31'd0, valid_W}, 32'd0);
    check("rst_wd", WriteData_W, 32'd0);
    reset = 1'b1;

    // ALU capture
    cyc(1'b1, 32'h0000_3000, 1'b1, 5'd5, 32'h1234_5678, 32'd0, 3'd0, 2'b00, 1'b0, 1'b0);
    check("alu_wd", WriteData_W, 32'h1234_5678);
    check("alu_we", {31'd0, RegWrite_W}, 32'd1);
    check("alu_wa", {27'd0, WAddr_W}, 32'd5);

    // sub-word loads of 0x80FF_7F01
    cyc(1'b1, 32'h3004, 1'b1, 5'd6, 32'h0000_1003, 32'h80FF_7F01, 3'd1, 2'b01, 1'b0, 1'b0);
    check("lb_off3", WriteData_W, 32'hFFFF_FF80);
    cyc(1'b1, 32'h3008, 1'b1, 5'd6, 32'h0000_1003, 32'h80FF_7F01, 3'd2, 2'b01, 1'b0, 1'b0);
    check("lbu_off3", WriteData_W, 32'h0000_0080);
    cyc(1'b1, 32'h300C, 1'b1, 5'd6, 32'h0000_1002, 32'h80FF_7F01, 3'd3, 2'b01, 1'b0, 1'b0);
    check("lh_off2", WriteData_W, 32'hFFFF_80FF);
    cyc(1'b1, 32'h3010, 1'b1, 5'd6, 32'h0000_1000, 32'h80FF_7F01, 3'd4, 2'b01, 1'b0, 1'b0);
    check("lhu_off0", WriteData_W, 32'h0000_7F01);
    cyc(1'b1, 32'h3014, 1'b1, 5'd6, 32'h0000_1001, 32'h80FF_7F01, 3'd1, 2'b01, 1'b0, 1'b0);
    check("lb_off1", WriteData_W, 32'h0000_007F);
    cyc(1'b1, 32'h3018, 1'b1, 5'd6, 32'h0000_1001, 32'h80FF_7F01, 3'd7, 2'b01, 1'b0, 1'b0);
    check("lw_other", WriteData_W, 32'h80FF_7F01);

    // link, $0, wrap
    cyc(1'b1, 32'h0000_3010, 1'b1, 5'd31, 32'h0, 32'h0, 3'd0, 2'b10, 1'b0, 1'b0);
    check("link", WriteData_W, 32'h0000_3018);
    cyc(1'b1, 32'h0000_3014, 1'b1, 5'd0, 32'h55, 32'h0, 3'd0, 2'b00, 1'b0, 1'b0);
    check("r0_we", {31'd0, RegWrite_W}, 32'd0);
    cyc(1'b1, 32'hFFFF_FFFC, 1'b1, 5'd31, 32'h0, 32'h0, 3'd0, 2'b10, 1'b0, 1'b0);
    check("link_wrap", WriteData_W, 32'h0000_0004);
    cyc(1'b0, 32'h0000_3020, 1'b1, 5'd7, 32'h77, 32'h0, 3'd0, 2'b00, 1'b0, 1'b0);
    check("inval_we", {31'd0, RegWrite_W}, 32'd0);

    // stall for 3 cycles with changing M inputs
    cyc(1'b1, 32'h0000_3100, 1'b1, 5'd9, 32'hCAFE_0001, 32'h0, 3'd0, 2'b00, 1'b0, 1'b0);
    held_wd = WriteData_W;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'h4000 + 32'(i), 1'b1, 5'(i + 1), $urandom, $urandom, 3'd0, 2'b00, 1'b1, 1'b0);
      check("stall_wd", WriteData_W, 32'hCAFE_0001);
      check("stall_pc", PC_W, 32'h0000_3100);
    end
    check("stall_held", held_wd, 32'hCAFE_0001);
    cyc(1'b1, 32'h0000_3200, 1'b1, 5'd9, 32'h1, 32'h0, 3'd0, 2'b00, 1'b1, 1'b1);
    check("flush_valid", {31'd0, valid_W}, 32'd0);
    check("flush_we", {31'd0, RegWrite_W}, 32'd0);
    check("flush_pc", PC_W, 32'h0000_3000);

    // async reset between edges
    cyc(1'b1, 32'h0000_3300, 1'b1, 5'd3, 32'hABCD, 32'h0, 3'd0, 2'b00, 1'b0, 1'b0);
    #1 reset = 1'b0;
    #1;
    check("arst_valid", {31'd0, valid_W}, 32'd0);
    check("arst_pc", PC_W, 32'h0000_3000);
    check("arst_wd", WriteData_W, 32'd0);
    check("arst_cnt", retire_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // retire counter: 10 valid captures, one empty capture, 2 stalls
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 32'h3000 + 32'(4 * i), 1'b1, 5'd1, 32'(i), 32'h0, 3'd0, 2'b00, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 3'd0, 2'b00, 1'b0, 1'b0);
    cyc(1'b1, 32'h0, 1'b1, 5'd2, 32'h0, 32'h0, 3'd0, 2'b00, 1'b1, 1'b0);
    cyc(1'b1, 32'h0, 1'b1, 5'd2, 32'h0, 32'h0, 3'd0, 2'b00, 1'b1, 1'b0);
`ifdef RETIRE_CNT_EN
    exp_cnt = 32'd10;
`else
    exp_cnt = 32'd0;
`endif
    check("retire10", retire_cnt, exp_cnt);
    #1 reset = 1'b0;
    #1 check("retire_rst", retire_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, $urandom, 1'($urandom), 5'($urandom),
            $urandom, $urandom, 3'($urandom), 2'($urandom),
            ($urandom_range(0, 9) < 2) ? 1'b1 : 1'b0, ($urandom_range(0, 9) < 1) ? 1'b1 : 1'b0);
      @(negedge clk);
    end

    drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 3'd0, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
